// File: rtl/opendap_swd_link_ctrl_pkg.sv
// SWD link controller shared types.
// Link states, DP address constants, header decode helpers.
package opendap_swd_link_ctrl_pkg;

  localparam int W_LINK_STATE = 3;

  localparam logic [1:0] DP_ADDR_DPIDR     = 2'd0;
  localparam logic [1:0] DP_ADDR_TARGETSEL = 2'd3;

  typedef enum logic [W_LINK_STATE-1:0] {
    S_DORMANT  = 3'd0,
    S_LOCKOUT  = 3'd1,
    S_RESET    = 3'd2,
    S_TSEL     = 3'd3,
    S_WAIT_ID  = 3'd4,
    S_ACTIVE   = 3'd5,
    S_DESELECT = 3'd6
  } link_state_e;

  typedef struct packed {
    logic       ok;
    logic       apndp;
    logic       rnw;
    logic [1:0] addr;
  } swd_hdr_t;

  function automatic logic is_dpidr_rd(swd_hdr_t h);
    return h.ok & ~h.apndp & h.rnw
         & (h.addr == DP_ADDR_DPIDR);
  endfunction

  function automatic logic is_tsel_wr(swd_hdr_t h);
    return h.ok & ~h.apndp & ~h.rnw
         & (h.addr == DP_ADDR_TARGETSEL);
  endfunction

  function automatic logic is_legal(link_state_e s);
    return s inside {S_DORMANT, S_LOCKOUT,
                     S_RESET, S_TSEL, S_WAIT_ID,
                     S_ACTIVE, S_DESELECT};
  endfunction

endpackage

// File: rtl/opendap_swd_link_ctrl_if.sv
// Event/header bundle between the dormant monitor,
// serial engine and the link controller.
interface opendap_swd_link_ctrl_if;
  logic        exit_dormant;
  logic        enter_dormant;
  logic        line_reset;
  logic        hdr_valid;
  logic        hdr_ok;
  logic        hdr_apndp;
  logic        hdr_rnw;
  logic [1:0]  hdr_addr;
  logic        wdata_valid;
  logic        wdata_ok;
  logic [31:0] wdata;
  logic        respond;
  logic        link_dormant;
  logic        link_active;
  logic        proto_err;

  modport master (
    output exit_dormant, enter_dormant,
           line_reset, hdr_valid, hdr_ok,
           hdr_apndp, hdr_rnw, hdr_addr,
           wdata_valid, wdata_ok, wdata,
    input  respond, link_dormant,
           link_active, proto_err
  );

  modport slave (
    input  exit_dormant, enter_dormant,
           line_reset, hdr_valid, hdr_ok,
           hdr_apndp, hdr_rnw, hdr_addr,
           wdata_valid, wdata_ok, wdata,
    output respond, link_dormant,
           link_active, proto_err
  );
endinterface

// File: rtl/opendap_swd_link_ctrl.sv
// SWD link state tracker: dormant/reset/select/active/lockout,
// gating ACK per header and handling multidrop TARGETSEL.
module opendap_swd_link_ctrl
  import opendap_swd_link_ctrl_pkg::*;
#(
  parameter bit          DORMANT_AT_RESET = 1'b1,
  parameter bit          MULTIDROP        = 1'b1,
  parameter logic [31:0] TARGETID         = 32'h00000001
) (
  input  logic swclk,
  input  logic rst_n,
  opendap_swd_link_ctrl_if.slave lk
);

  localparam link_state_e RST_STATE =
    DORMANT_AT_RESET ? S_DORMANT : S_LOCKOUT;

  link_state_e state_q, state_d;
  logic        perr_d, perr_q;
  logic        dorm_q, act_q;
  logic        resp;
  swd_hdr_t    hdr;
  logic        id_match;

  assign hdr = '{ok:    lk.hdr_ok,
                 apndp: lk.hdr_apndp,
                 rnw:   lk.hdr_rnw,
                 addr:  lk.hdr_addr};

  assign id_match = lk.wdata_ok
                  & (lk.wdata == TARGETID);

  // Next state and ACK decision; events in fixed priority order.
  always_comb begin
    state_d = state_q;
    perr_d  = 1'b0;
    resp    = 1'b0;
    if (!is_legal(state_q)) begin
      state_d = S_LOCKOUT;
    end
    if (lk.enter_dormant) begin
      state_d = S_DORMANT;
    end else if (lk.line_reset) begin
      if (state_q != S_DORMANT) begin
        state_d = S_RESET;
      end
    end else if (lk.exit_dormant) begin
      if (state_q == S_DORMANT) begin
        state_d = S_LOCKOUT;
      end
    end else if (lk.wdata_valid) begin
      if (state_q == S_TSEL) begin
        state_d = id_match ? S_WAIT_ID
                           : S_DESELECT;
      end
    end else if (lk.hdr_valid) begin
      case (state_q)
        S_RESET: begin
          if (is_dpidr_rd(hdr)) begin
            state_d = S_ACTIVE;
            resp    = 1'b1;
          end else if (MULTIDROP
                       && is_tsel_wr(hdr)) begin
            state_d = S_TSEL;
          end else begin
            state_d = S_LOCKOUT;
            perr_d  = ~hdr.ok;
          end
        end
        S_TSEL: begin
          state_d = S_DESELECT;
        end
        S_WAIT_ID: begin
          if (is_dpidr_rd(hdr)) begin
            state_d = S_ACTIVE;
            resp    = 1'b1;
          end else begin
            state_d = S_LOCKOUT;
            perr_d  = ~hdr.ok;
          end
        end
        S_ACTIVE: begin
          if (hdr.ok) begin
            resp = 1'b1;
          end else begin
            state_d = S_LOCKOUT;
            perr_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register with registered status flags.
  always_ff @(posedge swclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_STATE;
      perr_q  <= 1'b0;
      dorm_q  <= DORMANT_AT_RESET;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      perr_q  <= perr_d;
      dorm_q  <= (state_d == S_DORMANT);
      act_q   <= (state_d == S_ACTIVE);
    end
  end

  assign lk.respond      = resp;
  assign lk.link_dormant = dorm_q;
  assign lk.link_active  = act_q;
  assign lk.proto_err    = perr_q;

endmodule

// File: tb/tb_opendap_swd_link_ctrl.sv
// Directed bench for opendap_swd_link_ctrl
// (DORMANT_AT_RESET=1, MULTIDROP=1, TARGETID=1).
module tb_opendap_swd_link_ctrl;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  opendap_swd_link_ctrl_if lk ();

  opendap_swd_link_ctrl #(
    .DORMANT_AT_RESET(1'b1),
    .MULTIDROP       (1'b1),
    .TARGETID        (32'h00000001)
  ) dut (
    .swclk(clk),
    .rst_n(rst_n),
    .lk   (lk)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic idle();
    lk.exit_dormant  = 1'b0;
    lk.enter_dormant = 1'b0;
    lk.line_reset    = 1'b0;
    lk.hdr_valid     = 1'b0;
    lk.hdr_ok        = 1'b0;
    lk.hdr_apndp     = 1'b0;
    lk.hdr_rnw       = 1'b0;
    lk.hdr_addr      = 2'd0;
    lk.wdata_valid   = 1'b0;
    lk.wdata_ok      = 1'b0;
    lk.wdata         = 32'd0;
  endtask

  // 0 exit_dormant, 1 enter_dormant, 2 line_reset
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0: lk.exit_dormant  = 1'b1;
      1: lk.enter_dormant = 1'b1;
      default: lk.line_reset = 1'b1;
    endcase
    @(posedge clk);
    #1 idle();
  endtask

  task automatic hdr(input string tag,
                     input logic ok, input logic ap,
                     input logic rnw, input logic [1:0] a,
                     input logic exp_resp);
    @(negedge clk);
    lk.hdr_valid = 1'b1;
    lk.hdr_ok    = ok;
    lk.hdr_apndp = ap;
    lk.hdr_rnw   = rnw;
    lk.hdr_addr  = a;
    #1 chk(tag, {31'd0, lk.respond},
           {31'd0, exp_resp});
    @(posedge clk);
    #1 idle();
  endtask

  task automatic wd(input logic ok,
                    input logic [31:0] d);
    @(negedge clk);
    lk.wdata_valid = 1'b1;
    lk.wdata_ok    = ok;
    lk.wdata       = d;
    @(posedge clk);
    #1 idle();
  endtask

  task automatic st(input string tag,
                    input logic d, input logic a,
                    input logic p);
    chk({tag, ".dorm"}, {31'd0, lk.link_dormant},
        {31'd0, d});
    chk({tag, ".act"}, {31'd0, lk.link_active},
        {31'd0, a});
    chk({tag, ".perr"}, {31'd0, lk.proto_err},
        {31'd0, p});
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 st("reset", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Dormant ignores headers and line reset
    hdr("dorm_hdr", 1, 0, 1, 2'd0, 1'b0);
    st("dorm_hdr", 1'b1, 1'b0, 1'b0);
    pulse(2);
    st("dorm_lr", 1'b1, 1'b0, 1'b0);

    // Exit dormant -> lockout; headers ignored
    pulse(0);
    st("exit", 1'b0, 1'b0, 1'b0);
    hdr("lock_dpidr", 1, 0, 1, 2'd0, 1'b0);
    hdr("lock_bad", 0, 0, 1, 2'd0, 1'b0);
    st("lock_bad", 1'b0, 1'b0, 1'b0);

    // Line reset, DPIDR read -> active
    pulse(2);
    hdr("rst_dpidr", 1, 0, 1, 2'd0, 1'b1);
    st("active", 1'b0, 1'b1, 1'b0);

    // Active: ordinary headers ACKed
    hdr("act_dprd1", 1, 0, 1, 2'd1, 1'b1);
    hdr("act_apwr", 1, 1, 0, 2'd2, 1'b1);
    st("act_stay", 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    lk.hdr_ok = 1'b1;
    lk.hdr_rnw = 1'b1;
    #1 chk("novalid", {31'd0, lk.respond}, 32'd0);
    idle();

    // Active bad header -> lockout + proto_err
    hdr("act_bad", 0, 0, 1, 2'd0, 1'b0);
    st("act_bad", 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 chk("perr_pulse", {31'd0, lk.proto_err},
           32'd0);
    hdr("lock2_dpidr", 1, 0, 1, 2'd0, 1'b0);

    // Multidrop select with matching id
    pulse(2);
    hdr("tsel", 1, 0, 0, 2'd3, 1'b0);
    wd(1'b1, 32'h00000001);
    st("waitid", 1'b0, 1'b0, 1'b0);
    hdr("wid_dpidr", 1, 0, 1, 2'd0, 1'b1);
    st("sel_act", 1'b0, 1'b1, 1'b0);

    // Mismatched id -> deselected
    pulse(2);
    st("lr_act", 1'b0, 1'b0, 1'b0);
    hdr("tsel2", 1, 0, 0, 2'd3, 1'b0);
    wd(1'b1, 32'h00000002);
    hdr("desel_dpidr", 1, 0, 1, 2'd0, 1'b0);
    hdr("desel_bad", 0, 0, 1, 2'd0, 1'b0);
    st("desel", 1'b0, 1'b0, 1'b0);

    // Matching id with bad parity -> deselected
    pulse(2);
    hdr("tsel3", 1, 0, 0, 2'd3, 1'b0);
    wd(1'b0, 32'h00000001);
    hdr("par_dpidr", 1, 0, 1, 2'd0, 1'b0);

    // Header before write data -> deselected
    pulse(2);
    hdr("tsel4", 1, 0, 0, 2'd3, 1'b0);
    hdr("tsel_hdr", 1, 0, 1, 2'd0, 1'b0);
    hdr("mal_dpidr", 1, 0, 1, 2'd0, 1'b0);

    // Wait-id with non-DPIDR good header -> lockout
    pulse(2);
    hdr("tsel5", 1, 0, 0, 2'd3, 1'b0);
    wd(1'b1, 32'h00000001);
    hdr("wid_other", 1, 1, 1, 2'd0, 1'b0);
    st("wid_other", 1'b0, 1'b0, 1'b0);
    hdr("wid_lock", 1, 0, 1, 2'd0, 1'b0);

    // Wrong first header in reset, no proto_err
    pulse(2);
    hdr("rst_dpwr1", 1, 0, 0, 2'd1, 1'b0);
    st("rst_dpwr1", 1'b0, 1'b0, 1'b0);
    hdr("rst_lock", 1, 0, 1, 2'd0, 1'b0);

    // Bad header in reset -> proto_err
    pulse(2);
    hdr("rst_bad", 0, 0, 1, 2'd0, 1'b0);
    st("rst_bad", 1'b0, 1'b0, 1'b1);

    // Active then enter_dormant + line_reset
    pulse(2);
    hdr("rst_dpidr2", 1, 0, 1, 2'd0, 1'b1);
    @(negedge clk);
    lk.enter_dormant = 1'b1;
    lk.line_reset    = 1'b1;
    @(posedge clk);
    #1 idle();
    st("ent_dorm", 1'b1, 1'b0, 1'b0);
    hdr("dorm2_hdr", 1, 0, 1, 2'd0, 1'b0);

    // Line reset coincident with header
    pulse(0);
    pulse(2);
    hdr("rst_dpidr3", 1, 0, 1, 2'd0, 1'b1);
    @(negedge clk);
    lk.line_reset = 1'b1;
    lk.hdr_valid  = 1'b1;
    lk.hdr_ok     = 1'b1;
    lk.hdr_rnw    = 1'b1;
    #1 chk("lr_hdr", {31'd0, lk.respond}, 32'd0);
    @(posedge clk);
    #1 idle();
    st("lr_hdr", 1'b0, 1'b0, 1'b0);
    hdr("lr_dpidr", 1, 0, 1, 2'd0, 1'b1);
    st("lr_act", 1'b0, 1'b1, 1'b0);

    // Asynchronous reset mid-session
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 st("async_rst", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    hdr("post_rst", 1, 0, 1, 2'd0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
